// File: rtl/seq_alu_if.sv
// Operand/opcode request and registered result/flag bus for seq_alu.
// The master drives requests; the ALU (slave) returns status, result and flags.
interface seq_alu_if #(
  parameter int unsigned N = 4
);
  logic         start;
  logic [3:0]   op;
  logic [N-1:0] num1;
  logic [N-1:0] num2;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  logic         Z;
  logic         N_flag;
  logic         V;
  logic         C;

  modport master (
    output start, op, num1, num2,
    input  busy, done, result, Z, N_flag, V, C
  );

  modport slave (
    input  start, op, num1, num2,
    output busy, done, result, Z, N_flag, V, C
  );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle N-bit ALU with start/done handshake and registered result/flags.
// Define SEQ_ALU_MULDIV_EN to build the iterative MUL/DIV/MOD datapath.
module seq_alu #(
  parameter int unsigned N = 4
) (
  input logic    clk,
  input logic    rst_n,
  seq_alu_if.slave bus
);
  localparam int unsigned Sw = $clog2(N);

`ifdef SEQ_ALU_MULDIV_EN
  typedef enum logic [1:0] {StIdle, StExec, StIter} state_e;
`else
  typedef enum logic [1:0] {StIdle, StExec} state_e;
`endif

  state_e       state_q, state_d;
  logic [N-1:0] result_q;
  logic         z_q, n_q, v_q, c_q;

  logic         upd;
  logic [N-1:0] res_new;
  logic         c_new, v_new;

  // Single-cycle results, evaluated from the live request so they are ready at acceptance.
  logic [N:0]    sum, dif;
  logic [Sw-1:0] shamt;
  logic [N-1:0]  s_res;
  logic          s_c, s_v;

  always_comb begin
    sum   = {1'b0, bus.num1} + {1'b0, bus.num2};
    dif   = {1'b0, bus.num1} - {1'b0, bus.num2};
    shamt = bus.num2[Sw-1:0];
    s_res = '0;
    s_c   = 1'b0;
    s_v   = 1'b0;
    case (bus.op)
      4'd0: begin
        s_res = sum[N-1:0];
        s_c   = sum[N];
        s_v   = (bus.num1[N-1] == bus.num2[N-1]) && (sum[N-1] != bus.num1[N-1]);
      end
      4'd1: begin
        s_res = dif[N-1:0];
        s_c   = dif[N];
        s_v   = (bus.num1[N-1] != bus.num2[N-1]) && (dif[N-1] != bus.num1[N-1]);
      end
      4'd2:    s_res = bus.num1 & bus.num2;
      4'd3:    s_res = bus.num1 | bus.num2;
      4'd4:    s_res = bus.num1 ^ bus.num2;
      4'd5:    s_res = bus.num1 << shamt;
      4'd6:    s_res = bus.num1 >> shamt;
      default: s_res = '0;
    endcase
  end

`ifdef SEQ_ALU_MULDIV_EN
  // acc_q holds {high, low}: product for MUL, {remainder, dividend/quotient} for DIV/MOD.
  logic [Sw-1:0]  cnt_q, cnt_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [N-1:0]   opnd_q, opnd_d;
  logic [3:0]     op_q, op_d;
  logic [N:0]     mul_hi;
  logic [N+1:0]   div_diff;
  logic [2*N-1:0] mul_step, div_step;
  logic           is_div;

  always_comb begin
    mul_hi   = acc_q[0] ? ({1'b0, acc_q[2*N-1:N]} + {1'b0, opnd_q}) : {1'b0, acc_q[2*N-1:N]};
    mul_step = {mul_hi, acc_q[N-1:1]};
    div_diff = {1'b0, acc_q[2*N-1:N-1]} - {2'b00, opnd_q};
    div_step = div_diff[N+1] ? {acc_q[2*N-2:0], 1'b0}
                             : {div_diff[N-1:0], acc_q[N-2:0], 1'b1};
    is_div   = (bus.op == 4'd8) || (bus.op == 4'd9);
  end
`endif

  always_comb begin
    state_d = state_q;
    upd     = 1'b0;
    res_new = '0;
    c_new   = 1'b0;
    v_new   = 1'b0;
`ifdef SEQ_ALU_MULDIV_EN
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    op_d    = op_q;
`endif
    case (state_q)
      StIdle: begin
        if (bus.start) begin
`ifdef SEQ_ALU_MULDIV_EN
          if (bus.op == 4'd7 || (is_div && bus.num2 != '0)) begin
            op_d    = bus.op;
            cnt_d   = Sw'(N - 1);
            acc_d   = {{N{1'b0}}, (bus.op == 4'd7) ? bus.num2 : bus.num1};
            opnd_d  = (bus.op == 4'd7) ? bus.num1 : bus.num2;
            state_d = StIter;
          end else if (is_div) begin
            upd     = 1'b1;
            v_new   = 1'b1;
            state_d = StExec;
          end else begin
            upd     = 1'b1;
            res_new = s_res;
            c_new   = s_c;
            v_new   = s_v;
            state_d = StExec;
          end
`else
          upd     = 1'b1;
          res_new = s_res;
          c_new   = s_c;
          v_new   = s_v;
          state_d = StExec;
`endif
        end
      end
      StExec: state_d = StIdle;
`ifdef SEQ_ALU_MULDIV_EN
      StIter: begin
        acc_d = (op_q == 4'd7) ? mul_step : div_step;
        if (cnt_q == '0) begin
          upd     = 1'b1;
          state_d = StExec;
          case (op_q)
            4'd7: begin
              res_new = mul_step[N-1:0];
              c_new   = |mul_step[2*N-1:N];
            end
            4'd8:    res_new = div_step[N-1:0];
            default: res_new = div_step[2*N-1:N];
          endcase
        end else begin
          cnt_d = cnt_q - Sw'(1);
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      result_q <= '0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      v_q      <= 1'b0;
      c_q      <= 1'b0;
`ifdef SEQ_ALU_MULDIV_EN
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      op_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (upd) begin
        result_q <= res_new;
        z_q      <= (res_new == '0);
        n_q      <= res_new[N-1];
        v_q      <= v_new;
        c_q      <= c_new;
      end
`ifdef SEQ_ALU_MULDIV_EN
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
      op_q   <= op_d;
`endif
    end
  end

  assign bus.busy   = (state_q != StIdle);
  assign bus.done   = (state_q == StExec);
  assign bus.result = result_q;
  assign bus.Z      = z_q;
  assign bus.N_flag = n_q;
  assign bus.V      = v_q;
  assign bus.C      = c_q;
endmodule

// File: tb/tb_seq_alu.sv
// Randomised and directed bench for seq_alu against an arithmetic reference model.
// Expectations follow SEQ_ALU_MULDIV_EN when it is defined for the build.
module tb_seq_alu;
  localparam int N = 4;
  localparam int M = 1 << N;
  localparam int H = M / 2;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;

  seq_alu_if #(.N(N)) bus ();

  seq_alu #(.N(N)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int sgn(input int x);
    return (x >= H) ? x - M : x;
  endfunction

  // Expected outcome from the opcode definitions using plain integer arithmetic.
  function automatic void model(input int op, input int a, input int b, output int res,
                                output int z, output int n, output int v, output int c,
                                output int lat);
    int t;
    res = 0; v = 0; c = 0; lat = 1;
    case (op)
      0: begin
        t = a + b; res = t % M; c = (t >= M) ? 1 : 0;
        t = sgn(a) + sgn(b); v = (t > H - 1 || t < -H) ? 1 : 0;
      end
      1: begin
        res = (a - b + M) % M; c = (a < b) ? 1 : 0;
        t = sgn(a) - sgn(b); v = (t > H - 1 || t < -H) ? 1 : 0;
      end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: res = (a << (b % N)) % M;
      6: res = a >> (b % N);
`ifdef SEQ_ALU_MULDIV_EN
      7: begin
        t = a * b; res = t % M; c = (t >= M) ? 1 : 0; lat = N + 1;
      end
      8, 9: begin
        if (b == 0) v = 1;
        else begin
          res = (op == 8) ? a / b : a % b; lat = N + 1;
        end
      end
`endif
      default: res = 0;
    endcase
    z = (res == 0) ? 1 : 0;
    n = (res >= H) ? 1 : 0;
  endfunction

  task automatic run_op(input int op, input int a, input int b, input string tag);
    int er, ez, en, ev, ec, el, cyc, held;
    model(op, a, b, er, ez, en, ev, ec, el);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 4'(op);
    bus.num1  = 4'(a);
    bus.num2  = 4'(b);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.op    = 4'($urandom);
    bus.num1  = 4'($urandom);
    bus.num2  = 4'($urandom);
    chk({tag, ".busy1"}, int'(bus.busy), 1);
    cyc = 1;
    while (!bus.done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, ".lat"}, cyc, el);
    chk({tag, ".res"}, int'(bus.result), er);
    chk({tag, ".Z"}, int'(bus.Z), ez);
    chk({tag, ".N"}, int'(bus.N_flag), en);
    chk({tag, ".V"}, int'(bus.V), ev);
    chk({tag, ".C"}, int'(bus.C), ec);
    held = int'(bus.result);
    @(posedge clk); #1;
    chk({tag, ".done_fall"}, int'(bus.done), 0);
    chk({tag, ".busy_fall"}, int'(bus.busy), 0);
    chk({tag, ".hold"}, int'(bus.result), held);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".busy"}, int'(bus.busy), 0);
    chk({tag, ".done"}, int'(bus.done), 0);
    chk({tag, ".res"}, int'(bus.result), 0);
    chk({tag, ".Z"}, int'(bus.Z), 0);
    chk({tag, ".N"}, int'(bus.N_flag), 0);
    chk({tag, ".V"}, int'(bus.V), 0);
    chk({tag, ".C"}, int'(bus.C), 0);
  endtask

  initial begin
    int dones, prev, consec, er, ez, en, ev, ec, el;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op    = '0;
    bus.num1  = '0;
    bus.num2  = '0;
    #12;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_op(0, 7, 1, "add7_1");
    run_op(1, 3, 5, "sub3_5");
    run_op(7, 7, 3, "mul7_3");
    run_op(7, 3, 2, "mul3_2");
    run_op(8, 13, 4, "div13_4");
    run_op(9, 13, 4, "mod13_4");
    run_op(8, 9, 0, "div9_0");
    run_op(9, 9, 0, "mod9_0");
    run_op(7, 5, 5, "mul5_5");
    run_op(5, 9, 6, "shl");
    run_op(6, 9, 7, "shr");
    run_op(12, 9, 7, "op12");

    // start pulsed while busy must be ignored when the first op is still running
    model(7, 7, 3, er, ez, en, ev, ec, el);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 4'd7; bus.num1 = 4'd7; bus.num2 = 4'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    dones = 0;
    for (int cyc = 1; cyc <= N + 5; cyc++) begin
      dones += int'(bus.done);
      bus.start = (cyc == 2);
      bus.op = 4'd0; bus.num1 = 4'd1; bus.num2 = 4'd1;
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    chk("ignore_busy.dones", dones, (el > 2) ? 1 : 2);
    chk("ignore_busy.res", int'(bus.result), (el > 2) ? er : 2);

    // start held high: accepted again in the cycle after each done
    @(negedge clk);
    bus.start = 1'b1; bus.op = 4'd0; bus.num1 = 4'd2; bus.num2 = 4'd3;
    @(posedge clk); #1;
    dones = 0; prev = 0; consec = 0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      dones += int'(bus.done);
      if (bus.done && prev != 0) consec++;
      prev = int'(bus.done);
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("b2b.dones", dones, 4);
    chk("b2b.consec", consec, 0);
    chk("b2b.res", int'(bus.result), 5);

    // asynchronous reset during MUL iteration 2
    run_op(0, 7, 1, "pre_rst");
    @(negedge clk);
    bus.start = 1'b1; bus.op = 4'd7; bus.num1 = 4'd7; bus.num2 = 4'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(posedge clk); #1;
      dones += int'(bus.done);
    end
    chk("midrst.nodone", dones, 0);

    for (int i = 0; i < 150; i++) begin
      run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, M - 1)),
             int'($urandom_range(0, M - 1)), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
